// File: rtl/wr_console_tx.sv
// wr_console_tx
//   Bridge master that drains a host-filled command FIFO into the WR-core UART.
//   Polls the FIFO status register and pops one 32-bit word whenever the FIFO is
//   not empty. It unpacks the word MSB byte first and writes every non-zero byte
//   to the UART TX register. Before each byte it polls the UART status register
//   until TX is not busy. A byte that stays busy for TX_POLL_LIMIT polls is
//   dropped and counted.
//
//   Optional feature (macro WR_CONSOLE_TX_CRLF_EN): a bare LF (0x0A) that is not
//   preceded by a transmitted CR (0x0D) is sent as CR, LF. The inserted CR uses
//   the normal poll/timeout path.
//
// Ports
//   clock, nreset                 clock, asynchronous active-low reset
//   bridge_uart_acknowledge       bridge transfer complete
//   bridge_uart_read_data[31:0]   read data, valid with acknowledge
//   bridge_uart_read/_write       request strobes, held until acknowledged
//   bridge_uart_byte_enable[3:0]  byte lanes of the request
//   bridge_uart_address[8:0]      request address
//   bridge_uart_write_data[31:0]  write data
//   dropped_bytes[15:0]           saturating count of bytes dropped on TX timeout
module wr_console_tx #(
  parameter logic [8:0] CMD_FIFO_RD_REG     = 9'h104,
  parameter logic [8:0] CMD_FIFO_STATUS_REG = 9'h148,
  parameter logic [8:0] UART_ADDRESS_TX     = 9'h24,
  parameter logic [8:0] UART_ADDRESS_STATUS = 9'h28,
  parameter int         TX_POLL_LIMIT       = 1024
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        bridge_uart_acknowledge,
  input  logic [31:0] bridge_uart_read_data,
  output logic        bridge_uart_read,
  output logic        bridge_uart_write,
  output logic [3:0]  bridge_uart_byte_enable,
  output logic [8:0]  bridge_uart_address,
  output logic [31:0] bridge_uart_write_data,
  output logic [15:0] dropped_bytes
);

  localparam int PCW = $clog2(TX_POLL_LIMIT + 1);
  localparam logic [PCW-1:0] LAST_POLL = PCW'(TX_POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    S_CMD_STATUS = 3'd0,
    S_CMD_POP    = 3'd1,
    S_SELECT     = 3'd2,
    S_TX_STATUS  = 3'd3,
    S_TX_WRITE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [PCW-1:0]  poll_q, poll_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [3:0]      be_q, be_d;
  logic [8:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [15:0]     dropped_q, dropped_d;
`ifdef WR_CONSOLE_TX_CRLF_EN
  logic [7:0]      last_q, last_d;    // last byte actually written to the UART
  logic            ins_cr_q, ins_cr_d; // currently sending an inserted CR
`endif

  logic       req_active, ack;
  logic [7:0] cur_byte, tx_byte;
  logic       byte_done, advance;

  assign req_active = read_q | write_q;
  // Acknowledge only counts while one of our requests is outstanding.
  assign ack        = req_active & bridge_uart_acknowledge;
  // ~idx selects byte lane 3 for idx 0, so bytes go out MSB first.
  assign cur_byte   = word_q[{~idx_q, 3'b000} +: 8];
`ifdef WR_CONSOLE_TX_CRLF_EN
  assign tx_byte    = ins_cr_q ? 8'h0D : cur_byte;
`else
  assign tx_byte    = cur_byte;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    poll_d    = poll_q;
    read_d    = read_q;
    write_d   = write_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dropped_d = dropped_q;
`ifdef WR_CONSOLE_TX_CRLF_EN
    last_d    = last_q;
    ins_cr_d  = ins_cr_q;
`endif
    byte_done = 1'b0;
    advance   = 1'b0;

    // A completed transfer always drops the request. Because new requests are
    // only raised while nothing is outstanding, at least one idle cycle
    // separates two requests.
    if (ack) begin
      read_d  = 1'b0;
      write_d = 1'b0;
      be_d    = 4'h0;
      addr_d  = 9'h0;
      wdata_d = 32'h0;
    end

    case (state_q)
      S_CMD_STATUS: begin
        if (!req_active) begin
          read_d = 1'b1;
          be_d   = 4'h1;
          addr_d = CMD_FIFO_STATUS_REG;
        end else if (ack && !bridge_uart_read_data[0]) begin
          state_d = S_CMD_POP;
        end
      end
      S_CMD_POP: begin
        if (!req_active) begin
          read_d = 1'b1;
          be_d   = 4'hF;
          addr_d = CMD_FIFO_RD_REG;
        end else if (ack) begin
          word_d  = bridge_uart_read_data;
          idx_d   = 2'd0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (cur_byte == 8'h00) begin
          advance = 1'b1;
        end else begin
`ifdef WR_CONSOLE_TX_CRLF_EN
          if (cur_byte == 8'h0A && last_q != 8'h0D) ins_cr_d = 1'b1;
`endif
          poll_d  = '0;
          state_d = S_TX_STATUS;
        end
      end
      S_TX_STATUS: begin
        if (!req_active) begin
          read_d = 1'b1;
          be_d   = 4'h3;
          addr_d = UART_ADDRESS_STATUS;
        end else if (ack) begin
          if (!bridge_uart_read_data[6]) begin
            state_d = S_TX_WRITE;
          end else if (poll_q == LAST_POLL) begin
            if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
            byte_done = 1'b1;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      S_TX_WRITE: begin
        if (!req_active) begin
          write_d = 1'b1;
          be_d    = 4'h1;
          addr_d  = UART_ADDRESS_TX;
          wdata_d = {24'h0, tx_byte};
        end else if (ack) begin
`ifdef WR_CONSOLE_TX_CRLF_EN
          last_d = tx_byte;
`endif
          byte_done = 1'b1;
        end
      end
      default: state_d = S_CMD_STATUS;
    endcase

    // A finished inserted CR (sent or dropped) goes straight on to the LF it
    // was inserted for; anything else moves to the next byte lane.
    if (byte_done) begin
`ifdef WR_CONSOLE_TX_CRLF_EN
      if (ins_cr_q) begin
        ins_cr_d = 1'b0;
        poll_d   = '0;
        state_d  = S_TX_STATUS;
      end else begin
        advance = 1'b1;
      end
`else
      advance = 1'b1;
`endif
    end

    if (advance) begin
      if (idx_q == 2'd3) begin
        state_d = S_CMD_STATUS;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = S_SELECT;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_CMD_STATUS;
      idx_q     <= 2'd0;
      word_q    <= 32'h0;
      poll_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= 4'h0;
      addr_q    <= 9'h0;
      wdata_q   <= 32'h0;
      dropped_q <= 16'h0;
`ifdef WR_CONSOLE_TX_CRLF_EN
      last_q    <= 8'h00;
      ins_cr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      poll_q    <= poll_d;
      read_q    <= read_d;
      write_q   <= write_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dropped_q <= dropped_d;
`ifdef WR_CONSOLE_TX_CRLF_EN
      last_q    <= last_d;
      ins_cr_q  <= ins_cr_d;
`endif
    end
  end

  assign bridge_uart_read        = read_q;
  assign bridge_uart_write       = write_q;
  assign bridge_uart_byte_enable = be_q;
  assign bridge_uart_address     = addr_q;
  assign bridge_uart_write_data  = wdata_q;
  assign dropped_bytes           = dropped_q;

endmodule

// File: tb/tb_wr_console_tx.sv
// Testbench for wr_console_tx. A bridge responder with random acknowledge
// latency models the command FIFO and the UART. Known words are applied from a
// table with their expected UART bytes. A randomized run is then checked
// against a byte-level model of the console rules.
module tb_wr_console_tx;
  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        rd, wr;
  logic [3:0]  be;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [15:0] dropped;

  wr_console_tx #(.TX_POLL_LIMIT(LIMIT)) dut (
    .clock(clock), .nreset(nreset),
    .bridge_uart_acknowledge(ack), .bridge_uart_read_data(rdata),
    .bridge_uart_read(rd), .bridge_uart_write(wr),
    .bridge_uart_byte_enable(be), .bridge_uart_address(addr),
    .bridge_uart_write_data(wdata), .dropped_bytes(dropped)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- bridge responder + protocol monitor ----------------
  logic [31:0] words[$];      // command FIFO contents
  int          busy_q[$];     // busy polls per TX attempt
  logic [7:0]  written[$];    // bytes written to UART TX
  int          empty_cnt = 0; // forced "empty" answers before the FIFO shows data
  int          pops = 0;
  bit          after_pop = 0, status_after_pop = 0, hold_wr = 0;
  int          lat = -1;
  bit          att_open = 0;
  int          att_n = 0, att_polls = 0;
  bit          prev_req = 0, prev_ack = 0;
  logic [46:0] prev_sig = '0;

  always @(negedge clock) begin
    if (!nreset) begin
      ack = 1'b0; lat = -1; att_open = 0; prev_req = 0; prev_ack = 0;
    end else begin
      bit req, legal;
      req = rd | wr;
      if (prev_req && prev_ack) begin
        if (req) chk("idle_after_ack", {31'h0, req}, 32'h0);
      end else if (prev_req && req) begin
        if ({rd, wr, be, addr, wdata} !== prev_sig) chk("req_stable", 32'h0, 32'h1);
      end
      if (req && !(prev_req && !prev_ack)) begin
        legal = (rd && !wr && ((addr == 9'h148 && be == 4'h1) || (addr == 9'h104 && be == 4'hF) ||
                               (addr == 9'h28 && be == 4'h3))) ||
                (wr && !rd && addr == 9'h24 && be == 4'h1 && wdata[31:8] == 24'h0);
        chk("legal_req", {rd, wr, be, addr}, legal ? {rd, wr, be, addr} : 15'h7FFF);
      end
      prev_req = req;
      prev_sig = {rd, wr, be, addr, wdata};
      if (ack) begin
        ack = 1'b0;
      end else if (req && !(wr && hold_wr)) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          lat = -1;
          ack = 1'b1;
          rdata = $urandom;
          if (wr) begin
            written.push_back(wdata[7:0]);
            att_open = 0;
          end else if (addr == 9'h148) begin
            if (empty_cnt > 0) begin rdata[0] = 1'b1; empty_cnt--; end
            else rdata[0] = (words.size() == 0);
            if (after_pop) begin status_after_pop = 1; after_pop = 0; end
          end else if (addr == 9'h104) begin
            if (words.size() > 0) rdata = words.pop_front();
            pops++;
            after_pop = 1;
          end else if (addr == 9'h28) begin
            if (!att_open) begin
              att_open = 1; att_polls = 0;
              att_n = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
            end
            if (att_polls < att_n) begin
              rdata[6] = 1'b1; att_polls++;
              if (att_polls == LIMIT) att_open = 0;
            end else rdata[6] = 1'b0;
          end
        end else lat--;
      end
      prev_ack = ack;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  int         exp_drops = 0;
  logic [7:0] model_last = 8'h00;

  task automatic model_attempt(input logic [7:0] b);
    int n;
    n = ($urandom_range(0, 9) < 2) ? $urandom_range(LIMIT, LIMIT + 2) : $urandom_range(0, LIMIT - 1);
    busy_q.push_back(n);
    if (n >= LIMIT) exp_drops++;
    else begin exp_q.push_back(b); model_last = b; end
  endtask

  task automatic model_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      if (b != 8'h00) begin
`ifdef WR_CONSOLE_TX_CRLF_EN
        if (b == 8'h0A && model_last != 8'h0D) model_attempt(8'h0D);
`endif
        model_attempt(b);
      end
    end
  endtask

  // Push one word, wait for the DUT to return to FIFO polling, compare.
  task automatic run_word(input logic [31:0] w, input int empty_n, input string tag);
    bit done;
    done = 0;
    @(posedge clock); #1;
    written.delete(); status_after_pop = 0; after_pop = 0;
    empty_cnt = empty_n;
    words.push_back(w);
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clock); #1;
      done = status_after_pop;
    end
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_nbytes"}, written.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < written.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, written[i]}, {24'h0, exp_q[i]});
    chk({tag, "_dropped"}, {16'h0, dropped}, exp_drops);
    chk({tag, "_attempts_used"}, busy_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] word;
    int          empty_n;
    int          nbusy;
    logic [19:0] busy_b;   // busy polls per attempt, first attempt in top nibble
    int          exp_n;
    logic [39:0] exp_b;    // expected UART bytes, first in top byte
    int          exp_drop;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'h68656C70, 5, 4, 20'h00000, 4, 40'h68656C7000, 0};
    tbl[1] = '{32'h00410000, 0, 1, 20'h00000, 1, 40'h4100000000, 0};
    tbl[2] = '{32'h41000000, 0, 1, 20'h30000, 1, 40'h4100000000, 0};
    tbl[3] = '{32'h42430000, 1, 2, 20'h70000, 1, 40'h4300000000, 1};
    tbl[4] = '{32'h00000000, 0, 0, 20'h00000, 0, 40'h0000000000, 0};
`ifdef WR_CONSOLE_TX_CRLF_EN
    tbl[5] = '{32'h410A0000, 0, 3, 20'h00000, 3, 40'h410D0A0000, 0};
    tbl[6] = '{32'h0A000000, 0, 2, 20'h91000, 1, 40'h0A00000000, 1};
`else
    tbl[5] = '{32'h410A0000, 0, 2, 20'h00000, 2, 40'h410A000000, 0};
    tbl[6] = '{32'h0A000000, 0, 1, 20'h10000, 1, 40'h0A00000000, 0};
`endif
    tbl[7] = '{32'h0D0A0000, 0, 2, 20'h00000, 2, 40'h0D0A000000, 0};

    // reset state
    #1 nreset = 1'b0;
    #2;
    chk("rst_read", {31'h0, rd}, 0);
    chk("rst_write", {31'h0, wr}, 0);
    chk("rst_be", {28'h0, be}, 0);
    chk("rst_addr", {23'h0, addr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_dropped", {16'h0, dropped}, 0);
    #19 nreset = 1'b1;

    // table vectors
    for (int t = 0; t < 8; t++) begin
      exp_q.delete();
      for (int i = 0; i < tbl[t].nbusy; i++) busy_q.push_back(int'(tbl[t].busy_b[19-4*i -: 4]));
      for (int i = 0; i < tbl[t].exp_n; i++) exp_q.push_back(tbl[t].exp_b[39-8*i -: 8]);
      exp_drops += tbl[t].exp_drop;
      run_word(tbl[t].word, tbl[t].empty_n, $sformatf("tbl%0d", t));
      if (tbl[t].exp_n > 0) model_last = exp_q[exp_q.size()-1];
    end

    // reset while a UART write is pending without acknowledge
    begin
      bit seen;
      seen = 0;
      @(posedge clock); #1;
      hold_wr = 1; busy_q.push_back(0); words.push_back(32'h41000000);
      for (int c = 0; c < 500 && !seen; c++) begin @(negedge clock); seen = wr; end
      chk("rst_mid_write_seen", {31'h0, seen}, 1);
      #2 nreset = 1'b0;
      #1;
      chk("rst_mid_read", {31'h0, rd}, 0);
      chk("rst_mid_write", {31'h0, wr}, 0);
      chk("rst_mid_be", {28'h0, be}, 0);
      chk("rst_mid_addr", {23'h0, addr}, 0);
      chk("rst_mid_wdata", wdata, 0);
      chk("rst_mid_dropped", {16'h0, dropped}, 0);
      words.delete(); busy_q.delete(); written.delete();
      empty_cnt = 0; after_pop = 0; status_after_pop = 0;
      exp_drops = 0; model_last = 8'h00;
      @(negedge clock); #1;
      hold_wr = 0; nreset = 1'b1;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin @(negedge clock); seen = rd | wr; end
      chk("post_rst_req", {31'h0, seen}, 1);
      chk("post_rst_first", {rd, wr, be, addr}, {1'b1, 1'b0, 4'h1, 9'h148});
      chk("post_rst_written", written.size(), 0);
    end

    // randomized words against the model
    for (int n = 0; n < 25; n++) begin
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 9);
        w[8*i +: 8] = (r < 3) ? 8'h00 : (r == 3) ? 8'h0A : (r == 4) ? 8'h0D : 8'($urandom_range(1, 255));
      end
      exp_q.delete();
      model_word(w);
      run_word(w, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
